// File: rtl/hzd_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hzd_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    // Control state of the hazard unit.
    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StLdUse = 2'd1,
        StMWait = 2'd2
    } hzd_state_e;

    // Destination-register view of one downstream pipeline stage.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  wen;
        logic                  load;
    } shadow_t;

    // Shadow contents for an empty (bubble) stage.
    localparam shadow_t SHADOW_EMPTY = '{rd: '0, wen: 1'b0, load: 1'b0};

endpackage

// File: rtl/hzd_match.sv
// Source/destination register compare for one operand against one stage.
// x0 is hardwired to zero, so it never produces a dependency.
module hzd_match
    import hzd_pkg::*;
(
    input  logic                  use_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  wen_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output logic                  match_o
);

    // Dependency exists only for a real read of a non-zero register that the stage writes.
    always_comb begin
        match_o = use_i && (rs_i != '0) && wen_i && (rd_i == rs_i);
    end

endmodule

// File: rtl/hzd.sv
// Pipeline hazard unit: operand forwarding selects, load-use stall,
// branch flush and data-memory freeze for a 5-stage pipeline.
module hzd
    import hzd_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_id_valid,
    input  logic                  i_id_use_rs1,
    input  logic                  i_id_use_rs2,
    input  logic                  i_id_reg_wen,
    input  logic                  i_id_mem_reg,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_ex_br_taken,
    input  logic                  i_dmem_busy,
    output logic                  o_frwd_alu_op1,
    output logic                  o_frwd_mem_alu_op1,
    output logic                  o_frwd_mem_op1,
    output logic                  o_frwd_alu_op2,
    output logic                  o_frwd_mem_alu_op2,
    output logic                  o_frwd_mem_op2,
    output logic                  o_stall_if,
    output logic                  o_stall_id,
    output logic                  o_flush_id,
    output logic                  o_bubble_ex
);

    hzd_state_e state_q, state_d;
    shadow_t    ex_q, ex_d;
    shadow_t    mem_q, mem_d;

    logic ex_match1, ex_match2;
    logic mem_match1, mem_match2;

    logic fwd_alu1, fwd_mem_alu1, fwd_mem1;
    logic fwd_alu2, fwd_mem_alu2, fwd_mem2;
    logic load_use;
    logic frozen;
    logic flush;
    logic bubble;

    hzd_match u_match_ex_rs1 (
        .use_i   (i_id_use_rs1),
        .rs_i    (i_id_rs1),
        .wen_i   (ex_q.wen),
        .rd_i    (ex_q.rd),
        .match_o (ex_match1)
    );

    hzd_match u_match_ex_rs2 (
        .use_i   (i_id_use_rs2),
        .rs_i    (i_id_rs2),
        .wen_i   (ex_q.wen),
        .rd_i    (ex_q.rd),
        .match_o (ex_match2)
    );

    hzd_match u_match_mem_rs1 (
        .use_i   (i_id_use_rs1),
        .rs_i    (i_id_rs1),
        .wen_i   (mem_q.wen),
        .rd_i    (mem_q.rd),
        .match_o (mem_match1)
    );

    hzd_match u_match_mem_rs2 (
        .use_i   (i_id_use_rs2),
        .rs_i    (i_id_rs2),
        .wen_i   (mem_q.wen),
        .rd_i    (mem_q.rd),
        .match_o (mem_match2)
    );

    // Forwarding candidates: the younger EX producer shadows any MEM producer.
    always_comb begin
        fwd_alu1     = ex_match1 && !ex_q.load;
        fwd_mem_alu1 = !ex_match1 && mem_match1 && !mem_q.load;
        fwd_mem1     = !ex_match1 && mem_match1 && mem_q.load;
        fwd_alu2     = ex_match2 && !ex_q.load;
        fwd_mem_alu2 = !ex_match2 && mem_match2 && !mem_q.load;
        fwd_mem2     = !ex_match2 && mem_match2 && mem_q.load;
        // A load in EX has no data yet, so a dependent ID instruction must wait a cycle.
        load_use     = (ex_match1 || ex_match2) && ex_q.load;
        frozen       = i_dmem_busy;
        flush        = i_ex_br_taken;
    end

    // Hazard resolution: outputs, shadow pipeline advance and control state.
    always_comb begin
        o_frwd_alu_op1     = 1'b0;
        o_frwd_mem_alu_op1 = 1'b0;
        o_frwd_mem_op1     = 1'b0;
        o_frwd_alu_op2     = 1'b0;
        o_frwd_mem_alu_op2 = 1'b0;
        o_frwd_mem_op2     = 1'b0;
        o_stall_if         = 1'b0;
        o_stall_id         = 1'b0;
        o_flush_id         = 1'b0;
        o_bubble_ex        = 1'b0;
        bubble             = 1'b0;
        state_d            = state_q;
        ex_d               = ex_q;
        mem_d              = mem_q;

        if (i_rst) begin
            // Outputs stay low; the register block performs the clear.
            state_d = StRun;
        end else if (frozen) begin
            // Memory not ready: whole pipeline holds, nothing advances or is killed.
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
            state_d    = StMWait;
        end else begin
            if (flush) begin
                // Taken branch kills the ID instruction; a pending load-use no longer matters.
                o_flush_id  = 1'b1;
                bubble      = 1'b1;
            end else if (load_use) begin
                o_stall_if  = 1'b1;
                o_stall_id  = 1'b1;
                bubble      = 1'b1;
            end else begin
                o_frwd_alu_op1     = fwd_alu1;
                o_frwd_mem_alu_op1 = fwd_mem_alu1;
                o_frwd_mem_op1     = fwd_mem1;
                o_frwd_alu_op2     = fwd_alu2;
                o_frwd_mem_alu_op2 = fwd_mem_alu2;
                o_frwd_mem_op2     = fwd_mem2;
            end

            if (flush) begin
                o_frwd_alu_op1     = fwd_alu1;
                o_frwd_mem_alu_op1 = fwd_mem_alu1;
                o_frwd_mem_op1     = fwd_mem1;
                o_frwd_alu_op2     = fwd_alu2;
                o_frwd_mem_alu_op2 = fwd_mem_alu2;
                o_frwd_mem_op2     = fwd_mem2;
            end

            o_bubble_ex = bubble;

            // Advance the shadow pipeline.
            mem_d = ex_q;
            if (i_id_valid && !bubble) begin
                ex_d = '{rd: i_id_rd, wen: i_id_reg_wen, load: i_id_mem_reg};
            end else begin
                ex_d = SHADOW_EMPTY;
            end

            unique case (state_q)
                StRun:   state_d = (load_use && !flush) ? StLdUse : StRun;
                // The inserted bubble resolves the dependency after one cycle.
                StLdUse: state_d = StRun;
                // First unfrozen cycle re-evaluates as a normal cycle.
                StMWait: state_d = (load_use && !flush) ? StLdUse : StRun;
                default: state_d = StRun;
            endcase
        end
    end

    // State and shadow registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StRun;
            ex_q    <= SHADOW_EMPTY;
            mem_q   <= SHADOW_EMPTY;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_hzd.sv
// Self-checking bench for hzd: table of per-cycle vectors plus hand-written
// multi-cycle sequences, with expected outputs queued and compared each cycle.
module tb_hzd;

    logic       clk;
    logic       rst;
    logic       id_valid, id_use_rs1, id_use_rs2, id_reg_wen, id_mem_reg;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_br_taken, dmem_busy;
    logic       frwd_alu_op1, frwd_mem_alu_op1, frwd_mem_op1;
    logic       frwd_alu_op2, frwd_mem_alu_op2, frwd_mem_op2;
    logic       stall_if, stall_id, flush_id, bubble_ex;

    // Output vector bit layout: {fa1, fma1, fm1, fa2, fma2, fm2, stall_if, stall_id, flush, bubble}
    localparam logic [9:0] E_NONE = 10'h000;
    localparam logic [9:0] E_FA1  = 10'h200;
    localparam logic [9:0] E_FMA1 = 10'h100;
    localparam logic [9:0] E_FM1  = 10'h080;
    localparam logic [9:0] E_FA2  = 10'h040;
    localparam logic [9:0] E_FMA2 = 10'h020;
    localparam logic [9:0] E_FM2  = 10'h010;
    localparam logic [9:0] E_LU   = 10'h00D;
    localparam logic [9:0] E_FRZ  = 10'h00C;
    localparam logic [9:0] E_FLB  = 10'h003;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic       u1;
        logic       u2;
        logic       wen;
        logic       ld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       br;
        logic       busy;
        logic [9:0] exp;
    } vec_t;

    int         total;
    int         bad;
    logic [9:0] sb_q[$];
    string      nm_q[$];
    vec_t       tbl[18];

    hzd dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_id_valid         (id_valid),
        .i_id_use_rs1       (id_use_rs1),
        .i_id_use_rs2       (id_use_rs2),
        .i_id_reg_wen       (id_reg_wen),
        .i_id_mem_reg       (id_mem_reg),
        .i_id_rs1           (id_rs1),
        .i_id_rs2           (id_rs2),
        .i_id_rd            (id_rd),
        .i_ex_br_taken      (ex_br_taken),
        .i_dmem_busy        (dmem_busy),
        .o_frwd_alu_op1     (frwd_alu_op1),
        .o_frwd_mem_alu_op1 (frwd_mem_alu_op1),
        .o_frwd_mem_op1     (frwd_mem_op1),
        .o_frwd_alu_op2     (frwd_alu_op2),
        .o_frwd_mem_alu_op2 (frwd_mem_alu_op2),
        .o_frwd_mem_op2     (frwd_mem_op2),
        .o_stall_if         (stall_if),
        .o_stall_id         (stall_id),
        .o_flush_id         (flush_id),
        .o_bubble_ex        (bubble_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic a, input logic b,
                                input logic w, input logic l, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [4:0] d, input logic br,
                                input logic bz, input logic [9:0] e);
        vec_t t;
        t.rst  = r;
        t.vld  = v;
        t.u1   = a;
        t.u2   = b;
        t.wen  = w;
        t.ld   = l;
        t.rs1  = s1;
        t.rs2  = s2;
        t.rd   = d;
        t.br   = br;
        t.busy = bz;
        t.exp  = e;
        return t;
    endfunction

    // One cycle: drive after the rising edge, queue the expectation, check on the falling edge.
    task automatic cyc(input string nm, input vec_t v);
        logic [9:0] got;
        logic [9:0] want;
        string      n;
        @(posedge clk);
        #1;
        rst         = v.rst;
        id_valid    = v.vld;
        id_use_rs1  = v.u1;
        id_use_rs2  = v.u2;
        id_reg_wen  = v.wen;
        id_mem_reg  = v.ld;
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_rd       = v.rd;
        ex_br_taken = v.br;
        dmem_busy   = v.busy;
        sb_q.push_back(v.exp);
        nm_q.push_back(nm);
        @(negedge clk);
        got  = {frwd_alu_op1, frwd_mem_alu_op1, frwd_mem_op1, frwd_alu_op2, frwd_mem_alu_op2,
                frwd_mem_op2, stall_if, stall_id, flush_id, bubble_ex};
        want = sb_q.pop_front();
        n    = nm_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", n, got, want);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        id_valid    = 1'b0;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
        id_reg_wen  = 1'b0;
        id_mem_reg  = 1'b0;
        id_rs1      = '0;
        id_rs2      = '0;
        id_rd       = '0;
        ex_br_taken = 1'b0;
        dmem_busy   = 1'b0;

        //             rst v u1 u2 w l rs1 rs2 rd br bz exp
        tbl[0]  = mk(1, 1, 1, 0, 1, 0, 5, 0, 5, 0, 0, E_NONE);   // reset masks outputs
        tbl[1]  = mk(1, 1, 1, 0, 1, 0, 5, 0, 5, 0, 0, E_NONE);
        tbl[2]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 5, 0, 0, E_NONE);   // add x5
        tbl[3]  = mk(0, 1, 1, 0, 1, 0, 5, 0, 6, 0, 0, E_FA1);    // rs1=x5 from EX
        tbl[4]  = mk(0, 1, 1, 1, 0, 0, 5, 6, 0, 0, 0, E_FMA1 | E_FA2);
        tbl[5]  = mk(0, 1, 1, 1, 0, 0, 5, 6, 0, 0, 0, E_FMA2);   // x5 now in WB: none
        tbl[6]  = mk(0, 1, 1, 0, 1, 1, 0, 0, 7, 0, 0, E_NONE);   // lw x7
        tbl[7]  = mk(0, 1, 0, 1, 1, 0, 0, 7, 8, 0, 0, E_LU);     // load-use on rs2
        tbl[8]  = mk(0, 1, 0, 1, 1, 0, 0, 7, 8, 0, 0, E_FM2);
        tbl[9]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 3, 0, 0, E_NONE);   // add x3
        tbl[10] = mk(0, 1, 0, 0, 1, 0, 0, 0, 3, 0, 0, E_NONE);   // add x3
        tbl[11] = mk(0, 1, 1, 1, 0, 0, 3, 3, 0, 0, 0, E_FA1 | E_FA2);
        tbl[12] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_NONE);   // writes x0
        tbl[13] = mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, E_NONE);   // reads x0
        tbl[14] = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_NONE);
        tbl[15] = mk(0, 1, 0, 0, 1, 1, 0, 0, 9, 0, 0, E_NONE);   // lw x9
        tbl[16] = mk(0, 1, 1, 0, 0, 0, 9, 0, 0, 1, 0, E_FLB);    // branch beats load-use
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE);

        for (int i = 0; i < 18; i++) begin
            cyc($sformatf("row%0d", i), tbl[i]);
        end

        // Memory freeze with a load sitting in MEM.
        cyc("mw_lw",    mk(0, 1, 0, 0, 1, 1, 0, 0, 10, 0, 0, E_NONE));
        cyc("mw_add",   mk(0, 1, 0, 0, 1, 0, 0, 0, 11, 0, 0, E_NONE));
        cyc("mw_busy1", mk(0, 1, 1, 0, 1, 0, 10, 0, 12, 0, 1, E_FRZ));
        cyc("mw_busy2", mk(0, 1, 1, 0, 1, 0, 10, 0, 12, 0, 1, E_FRZ));
        cyc("mw_busy3", mk(0, 1, 1, 0, 1, 0, 10, 0, 12, 0, 1, E_FRZ));
        cyc("mw_free",  mk(0, 1, 1, 0, 1, 0, 10, 0, 12, 0, 0, E_FM1));

        // Reset arriving during a freeze, then normal evaluation straight after.
        cyc("rf_busy",  mk(0, 1, 1, 0, 0, 0, 12, 0, 0, 0, 1, E_FRZ));
        cyc("rf_rst",   mk(1, 1, 1, 0, 0, 0, 12, 0, 0, 0, 1, E_NONE));
        cyc("rf_after", mk(0, 1, 1, 0, 0, 0, 12, 0, 0, 0, 0, E_NONE));

        // Flush held across a freeze is acted on once memory is ready.
        cyc("fz_lw",    mk(0, 1, 0, 0, 1, 1, 0, 0, 13, 0, 0, E_NONE));
        cyc("fz_busy",  mk(0, 1, 0, 1, 0, 0, 0, 13, 0, 1, 1, E_FRZ));
        cyc("fz_flush", mk(0, 1, 0, 1, 0, 0, 0, 13, 0, 1, 0, E_FLB));
        cyc("fz_fwd",   mk(0, 1, 0, 1, 0, 0, 0, 13, 0, 0, 0, E_FM2));

        // Reset on a cycle that would otherwise be a load-use stall.
        cyc("rl_lw",    mk(0, 1, 0, 0, 1, 1, 0, 0, 14, 0, 0, E_NONE));
        cyc("rl_rst",   mk(1, 1, 1, 0, 0, 0, 14, 0, 0, 0, 0, E_NONE));
        cyc("rl_after", mk(0, 1, 1, 0, 0, 0, 14, 0, 0, 0, 0, E_NONE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
